// File: rtl/reduce_pkg.sv
// reduce_pkg: shared FSM state, default widths and saturation helper for the reduction slice
package reduce_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int W_DEF = 8;
  localparam int N_DEF = 8;
  localparam int ACC_W = W_DEF + $clog2(N_DEF);
  function automatic logic sat_needed(input logic [63:0] v, input int unsigned w);
    return (v >> w) != 64'd0;
  endfunction
endpackage

// File: rtl/reduce_alu.sv
// reduce_alu: stateless accumulate adder and output stage; REDUCE_SAT_EN selects saturate over wrap
module reduce_alu
  import reduce_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic [W+$clog2(N)-1:0] acc,
  input  logic [W-1:0]           op,
  output logic [W+$clog2(N)-1:0] sum,
  output logic [W-1:0]           c,
  output logic                   ovf
);
  always_comb begin
    sum = acc + {{$clog2(N){1'b0}}, op};
    ovf = sat_needed(64'(acc), W);
`ifdef REDUCE_SAT_EN
    c = ovf ? '1 : acc[W-1:0];
`else
    c = acc[W-1:0];
`endif
  end
endmodule

// File: rtl/reduce_sched.sv
// reduce_sched: buffers N operands, reduces them serially through reduce_alu; REDUCE_SAT_EN saturates c
module reduce_sched
  import reduce_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         ovf,
  output logic         busy
);
  localparam int AW = W + $clog2(N);
  localparam int IW = $clog2(N);
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [W-1:0] buf_q [N];
  logic [W-1:0] c_q, c_d, alu_c;
  logic fin_q, fin_d, ovf_q, ovf_d, alu_ovf;
  logic out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic take;
  reduce_alu #(.W(W), .N(N)) u_alu (
    .acc(acc_q),
    .op (buf_q[idx_q]),
    .sum(sum),
    .c  (alu_c),
    .ovf(alu_ovf)
  );
  assign take = in_valid && in_ready_q;
  // fin_q marks the extra RUN cycle that latches the final accumulator into c/ovf
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    fin_d = fin_q;
    acc_d = acc_q;
    c_d = c_q;
    ovf_d = ovf_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      idx_d = '0;
      fin_d = 1'b0;
      acc_d = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: if (take) begin
          cnt_d = cnt_q + 1'b1;
          state_d = LOAD;
          if (cnt_q == IW'(N - 1)) begin
            state_d = RUN;
            cnt_d = '0;
            idx_d = '0;
            acc_d = '0;
          end
        end
        RUN: if (fin_q) begin
          c_d = alu_c;
          ovf_d = alu_ovf;
          fin_d = 1'b0;
          state_d = DONE;
        end else begin
          acc_d = sum;
          idx_d = idx_q + 1'b1;
          fin_d = idx_q == IW'(N - 1);
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
    in_ready_d = state_d == IDLE || state_d == LOAD;
    out_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      fin_q <= 1'b0;
      acc_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fin_q <= fin_d;
      acc_q <= acc_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) if (take) buf_q[cnt_q] <= in_data;
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign c = c_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_reduce_sched.sv
// tb_reduce_sched: randomized and directed checks of reduce_sched against a plain-sum reference
module tb_reduce_sched;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, ovf, busy;
  logic [7:0] c;
  int total = 0, bad = 0;
  reduce_sched #(.W(8), .N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] v [8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      chk("in_ready_load", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data = v[i];
      tick();
      in_valid = 1'b0;
    end
  endtask
  task automatic finish(input logic [7:0] v [8], input int hold);
    int sum = 0, lat = 0;
    logic [7:0] exp_c;
    for (int i = 0; i < 8; i++) sum += int'(v[i]);
`ifdef REDUCE_SAT_EN
    exp_c = sum > 255 ? 8'hFF : sum[7:0];
`else
    exp_c = sum[7:0];
`endif
    while (!out_valid && lat < 40) begin
      chk("in_ready_run", 32'(in_ready), 0);
      chk("busy_run", 32'(busy), 1);
      tick();
      lat++;
    end
    chk("latency", lat, 9);
    chk("c", 32'(c), 32'(exp_c));
    chk("ovf", 32'(ovf), 32'(sum > 255));
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_c", 32'(c), 32'(exp_c));
      chk("hold_ovf", 32'(ovf), 32'(sum > 255));
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_ready", 32'(in_ready), 1);
  endtask
  task automatic idle_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] v [8];
    int lat;
    tick();
    tick();
    idle_state("reset");
    chk("reset_c", 32'(c), 0);
    chk("reset_ovf", 32'(ovf), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
    load(v, 0);
    finish(v, 0);
    for (int i = 0; i < 8; i++) v[i] = 8'hFF;
    load(v, 0);
    finish(v, 5);
    for (int i = 0; i < 8; i++) v[i] = 8'(10 * (i + 1));
    load(v, 1);
    finish(v, 1);
    for (int i = 0; i < 3; i++) v[i] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = v[i];
      tick();
    end
    in_data = 8'h77;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    idle_state("abort_load");
    for (int i = 0; i < 8; i++) v[i] = 8'd2;
    load(v, 0);
    finish(v, 0);
    in_valid = 1'b1;
    in_data = 8'd9;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_idle_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_state("abort_idle");
    for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
    load(v, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    idle_state("abort_done");
    load(v, 0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_state("rst_run");
    chk("rst_run_c", 32'(c), 0);
    chk("rst_run_ovf", 32'(ovf), 0);
    lat = 0;
    repeat (12) begin
      tick();
      lat += int'(out_valid);
    end
    chk("rst_no_result", lat, 0);
    load(v, 0);
    finish(v, 0);
    repeat (20) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) for (int i = 0; i < 8; i++) v[i] = v[i] >> 3;
      load(v, 1'($urandom_range(0, 1)));
      finish(v, $urandom_range(0, 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
